// File: rtl/cache_set_assoc.sv
// rtl/cache_set_assoc.sv - N-way set-associative tag-only cache with true-LRU replacement and flush
// Optional hit/miss statistics ports are enabled by defining CACHE_STATS_EN.
module cache_set_assoc #(
  parameter int ADDR_W   = 11,
  parameter int OFF_W    = 4,
  parameter int SET_W    = 3,
  parameter int WAYS     = 2,
  parameter int MISS_LAT = 4,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              busy
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - OFF_W - SET_W;
  localparam int NSETS = 1 << SET_W;
  localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [SET_W-1:0]   set_q;
  logic [SET_W-1:0]   fset_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WAY_W-1:0]   victim_q;

  logic [WAYS-1:0]    valid_q [NSETS];
  logic [TAG_W-1:0]   tags_q  [NSETS][WAYS];
  logic [WAY_W-1:0]   age_q   [NSETS][WAYS];

  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic               install;
  logic               touch_en;
  logic [WAY_W-1:0]   touch_way;
  logic               accept;
  logic               unused_offset;

  assign unused_offset = ^req_addr[OFF_W-1:0];
  assign accept        = (state_q == S_IDLE) && !flush && req_valid;
  assign install       = (state_q == S_REFILL) && (cnt_q == '0);
  assign touch_en      = install || ((state_q == S_LOOKUP) && hit);
  assign touch_way     = install ? victim_q : hit_way;

  // Descending loops let the lowest matching index win; an invalid way overrides the LRU pick.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_q][w] && (tags_q[set_q][w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[set_q][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_q][w]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (flush) state_d = S_FLUSH;
                else if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_IDLE : S_REFILL;
      S_REFILL: if (cnt_q == '0) state_d = S_IDLE;
      S_FLUSH:  if (fset_q == SET_W'(NSETS - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_way   = '0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_LOOKUP: if (hit) begin
        resp_valid = 1'b1;
        resp_hit   = 1'b1;
        resp_way   = hit_way;
      end
      S_REFILL: if (cnt_q == '0) begin
        resp_valid = 1'b1;
        resp_way   = victim_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      set_q    <= '0;
      fset_q   <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tags_q[s][w] <= '0;
          age_q[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      if (accept) begin
        tag_q <= req_addr[ADDR_W-1:OFF_W+SET_W];
        set_q <= req_addr[OFF_W+SET_W-1:OFF_W];
      end
      if ((state_q == S_IDLE) && flush) fset_q <= '0;
      if (state_q == S_FLUSH) begin
        fset_q          <= fset_q + 1'b1;
        valid_q[fset_q] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[fset_q][w] <= WAY_W'(w);
      end
      if ((state_q == S_LOOKUP) && !hit) begin
        cnt_q    <= CNT_W'(MISS_LAT - 1);
        victim_q <= victim;
      end
      if (state_q == S_REFILL) cnt_q <= cnt_q - 1'b1;
      if (install) begin
        tags_q[set_q][victim_q]  <= tag_q;
        valid_q[set_q][victim_q] <= 1'b1;
      end
      // True-LRU: ways younger than the touched one age by one, touched way becomes youngest.
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[set_q][w] < age_q[set_q][touch_way]) age_q[set_q][w] <= age_q[set_q][w] + 1'b1;
        end
        age_q[set_q][touch_way] <= '0;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (resp_valid) begin
      if (resp_hit && (hit_count_q != 16'hFFFF))   hit_count_q  <= hit_count_q + 16'd1;
      if (!resp_hit && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/cache_set_assoc.md
Name: cache_set_assoc

Overview:
- Parametrised N-way set-associative, tag-only cache model; next generation of the direct-mapped hit/miss cache.
- Accepts one address per request handshake and returns hit/miss after a lookup.
- Misses model a fixed refill latency before the line is installed.
- Adds true-LRU replacement, a multi-cycle flush, and optional hit/miss statistics.
- Sits between the address trace driver and the reporting logic of the cache simulator.

Parameters:
- ADDR_W, 11: request address width.
- OFF_W, 4: block-offset bits (16-byte blocks); offset is ignored for lookup.
- SET_W, 3: set-index bits, giving 2^SET_W sets.
- WAYS, 2: associativity; power of two, >=1.
- MISS_LAT, 4: refill cycles per miss; >=1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_addr  in  ADDR_W  request address.
- req_ready  out  1  block can accept a request or flush.
- flush  in  1  invalidate all lines; sampled only when req_ready=1.
- resp_valid  out  1  one-cycle pulse; result valid.
- resp_hit  out  1  1=hit, 0=miss; meaningful only with resp_valid.
- resp_way  out  clog2(WAYS) (min 1)  way that hit or was filled.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All valid bits cleared; LRU ages set to way index (way0 age 0 ... wayN-1 age WAYS-1).
  - FSM goes to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_hit=0, resp_way=0, busy=0.
  - Reset mid-refill or mid-flush aborts the operation; no line is installed.
- Address split:
  - tag = req_addr[ADDR_W-1:OFF_W+SET_W]
  - set = req_addr[OFF_W+SET_W-1:OFF_W]
  - Address is registered on acceptance.
- FSM states: IDLE, LOOKUP, REFILL, FLUSH.
- IDLE:
  - req_ready=1.
  - flush=1 → FLUSH, with flush taking priority over req_valid; the request is not accepted.
  - Otherwise req_valid=1 → accept, go to LOOKUP.
- LOOKUP (1 cycle, req_ready=0):
  - Compare the tag against every valid way of the set.
  - Hit: resp_valid=1, resp_hit=1, resp_way=matching way; LRU touch; → IDLE. Hit latency is 1 cycle after acceptance.
  - Miss: select victim, load the refill counter with MISS_LAT-1, → REFILL.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age WAYS-1.
- REFILL:
  - Counter decrements each cycle.
  - At 0: write tag, set valid, LRU touch victim, resp_valid=1, resp_hit=0, resp_way=victim, → IDLE.
  - Miss latency is 1+MISS_LAT cycles after acceptance.
- LRU touch(w):
  - Every way in the set whose age is less than age[w] increments by 1.
  - age[w] is set to 0.
  - Ages stay a permutation of 0..WAYS-1 at all times.
- FLUSH:
  - Clear valid bits of one set per cycle, starting at set 0; 2^SET_W cycles total.
  - Reset LRU ages of each cleared set as at reset.
  - → IDLE; no resp_valid pulse.
  - flush/req_valid inputs are ignored while in FLUSH.
- Boundary cases:
  - req_valid held high on the cycle a response is returned is accepted on the following IDLE cycle (req_ready is combinational from state).
  - Back-to-back hits give at most one request per 2 cycles.
  - Same address repeated after its miss response is a hit.
  - WAYS=1 degenerates to direct-mapped; LRU is unused.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count [15:0] and miss_count [15:0].
  - Each counter increments on resp_valid with the matching resp_hit value.
  - Counters saturate at 16'hFFFF.
  - Cleared by reset only; flush does not clear them.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then request 34 (set 2, tag 0) → miss, resp_valid 5 cycles after acceptance, resp_way=0. Request 34 again → hit, resp_way=0, resp_valid 1 cycle after acceptance.
- Request 200 (set 4, tag 1) → miss. Then 34 → hit. Then 528 (set 1, tag 4) → miss, no disturbance of set 0 or set 2.
- LRU in set 0, in order:
  - 512 → miss, way0
  - 768 → miss, way1
  - 1024 → miss, evicts 512 into way0
  - 768 → hit, way1
  - 512 → miss, evicts 1024 from way0
  - 1024 → miss, evicts 768 from way1
- Fill sets 0–7, assert flush → busy=1 for 8 cycles with req_ready=0. Then 34 → miss. Flush and req_valid asserted together in IDLE → flush wins and the request is accepted after FLUSH ends.
- Assert rst_n=0 during REFILL of 200 → outputs return to reset values immediately; no resp_valid pulse; next request 200 → miss.
- With CACHE_STATS_EN, trace 34,34,200,34,512,528,34,200,768,34 → hit_count=5, miss_count=5. Force the counter to 16'hFFFF, then one more hit → it stays 16'hFFFF.
